mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_grant.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 27;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant decision with starvation counter: fetch wins a contested grant once
// data has been granted STARVE_MAX times in a row while fetch was waiting.
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic   sys_clk,
    input  logic   sys_rst,
    input  logic   if_valid_i,
    input  logic   d_valid_i,
    input  logic   grant_en_i,
    output owner_t owner_o
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             starved;

    assign starved = (cnt_q == CNT_W'(STARVE_MAX));
    assign owner_o = (if_valid_i && (!d_valid_i || starved)) ? OWN_IF : OWN_D;

    always_comb begin
        cnt_d = cnt_q;
        if (!if_valid_i) begin
            cnt_d = '0;
        end else if (grant_en_i) begin
            if (owner_o == OWN_IF) begin
                cnt_d = '0;
            end else if (!starved) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data port arbiter in front of a single-request cache port.
// ARB_FAIR_EN enables the starvation-bounded grant (mem_arb_grant).
//
// state   | meaning
// IDLE    | no request outstanding; arbitrate on *_req_valid
// BUSY_IF | fetch request presented to the cache, waiting for cpu_res_ready
// BUSY_D  | data request presented to the cache, waiting for cpu_res_ready
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 3
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_res_valid,
    output logic [DATA_W-1:0] if_res_data,
    input  logic              d_req_valid,
    input  logic              d_req_rw,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_req_ready,
    output logic              d_res_valid,
    output logic [DATA_W-1:0] d_res_data,
    output logic [ADDR_W-1:0] cpu_req_addr,
    output logic [DATA_W-1:0] cpu_req_data,
    output logic              cpu_req_rw,
    output logic              cpu_req_valid,
    input  logic [DATA_W-1:0] cpu_res_data,
    input  logic              cpu_res_ready
);

    if (STARVE_MAX < 1) begin : g_starve_chk
        $error("STARVE_MAX must be at least 1");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic              if_ready_q, if_ready_d, d_ready_q, d_ready_d;
    logic              if_res_valid_q, if_res_valid_d, d_res_valid_q, d_res_valid_d;
    logic [DATA_W-1:0] if_res_data_q, if_res_data_d, d_res_data_q, d_res_data_d;
    owner_t            grant_owner;

`ifdef ARB_FAIR_EN
    logic grant_en;
    assign grant_en = (state_q == IDLE) && (if_req_valid || d_req_valid);

    mem_arb_grant #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .if_valid_i (if_req_valid),
        .d_valid_i  (d_req_valid),
        .grant_en_i (grant_en),
        .owner_o    (grant_owner)
    );
`else
    assign grant_owner = (if_req_valid && !d_req_valid) ? OWN_IF : OWN_D;
`endif

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rw_d           = rw_q;
        if_ready_d     = 1'b0;
        d_ready_d      = 1'b0;
        if_res_valid_d = 1'b0;
        d_res_valid_d  = 1'b0;
        if_res_data_d  = if_res_data_q;
        d_res_data_d   = d_res_data_q;
        case (state_q)
            IDLE: begin
                if (if_req_valid || d_req_valid) begin
                    if (grant_owner == OWN_IF) begin
                        state_d    = BUSY_IF;
                        addr_d     = if_req_addr;
                        wdata_d    = '0;
                        rw_d       = 1'b0;
                        if_ready_d = 1'b1;
                    end else begin
                        state_d    = BUSY_D;
                        addr_d     = d_req_addr;
                        wdata_d    = d_req_wdata;
                        rw_d       = d_req_rw;
                        d_ready_d  = 1'b1;
                    end
                end
            end
            BUSY_IF: begin
                if (cpu_res_ready) begin
                    state_d        = IDLE;
                    if_res_valid_d = 1'b1;
                    if_res_data_d  = cpu_res_data;
                end
            end
            BUSY_D: begin
                if (cpu_res_ready) begin
                    state_d       = IDLE;
                    d_res_valid_d = 1'b1;
                    // writes complete with zero data so the port never sees stale cache output
                    d_res_data_d  = rw_q ? '0 : cpu_res_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            rw_q           <= 1'b0;
            if_ready_q     <= 1'b0;
            d_ready_q      <= 1'b0;
            if_res_valid_q <= 1'b0;
            d_res_valid_q  <= 1'b0;
            if_res_data_q  <= '0;
            d_res_data_q   <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rw_q           <= rw_d;
            if_ready_q     <= if_ready_d;
            d_ready_q      <= d_ready_d;
            if_res_valid_q <= if_res_valid_d;
            d_res_valid_q  <= d_res_valid_d;
            if_res_data_q  <= if_res_data_d;
            d_res_data_q   <= d_res_data_d;
        end
    end

    assign if_req_ready  = if_ready_q;
    assign d_req_ready   = d_ready_q;
    assign if_res_valid  = if_res_valid_q;
    assign if_res_data   = if_res_data_q;
    assign d_res_valid   = d_res_valid_q;
    assign d_res_data    = d_res_data_q;
    assign cpu_req_addr  = addr_q;
    assign cpu_req_data  = wdata_q;
    assign cpu_req_rw    = rw_q;
    assign cpu_req_valid = (state_q != IDLE);

endmodule
